// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction-fetch stage.
package fetch_pkg;

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] RESET_PC  = 32'h0000_0000;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small circular buffer of fetched {instr, pc} entries; head reads as zero when empty.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CW = AW + 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t wdata,
    output logic [CW-1:0] count,
    output fetch_entry_t head
);

    fetch_entry_t     mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             pop_ok;
    logic             push_ok;

    assign pop_ok  = pop && (count != '0);
    assign push_ok = push && ((count < CW'(DEPTH)) || pop_ok);
    assign head    = (count != '0) ? mem[rd_ptr] : '0;

    // Pointers and occupancy; flush wins over any same-cycle push or pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            if (push_ok && !pop_ok)      count <= count + CW'(1);
            else if (pop_ok && !push_ok) count <= count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok && !flush) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC sequencing, single-outstanding imem reads, redirect/flush, decode handoff.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned      XLEN       = fetch_pkg::XLEN,
    parameter logic [XLEN-1:0]  RESET_PC   = fetch_pkg::RESET_PC,
    parameter int unsigned      FIFO_DEPTH = 2
) (
    input  logic            iClk,
    input  logic            iRst_n,
    output logic            oImemReq,
    output logic [XLEN-1:0] oImemAddr,
    input  logic            iImemGnt,
    input  logic            iImemRvalid,
    input  logic [XLEN-1:0] iImemRdata,
    output logic            oInstrValid,
    input  logic            iInstrReady,
    output logic [XLEN-1:0] oInstr,
    output logic [XLEN-1:0] oPC,
    output logic [6:0]      oOpcode,
    input  logic            iPCjump,
    input  logic [XLEN-1:0] iBranchPC,
    input  logic [XLEN-1:0] iBranchImm
);

    localparam int unsigned CW = ((FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1) + 1;

    fetch_state_t    state, state_d;
    logic [XLEN-1:0] fetch_pc, fetch_pc_d;
    logic [XLEN-1:0] req_pc, req_pc_d;
    logic [XLEN-1:0] jump_target;
    logic            fifo_push;
    logic            fifo_pop;
    logic            fifo_flush;
    logic [CW-1:0]   fifo_count;
    fetch_entry_t    fifo_wdata;
    fetch_entry_t    fifo_head;

    assign jump_target = (iBranchPC + iBranchImm) & ~(XLEN'(3));

    // Request is held off during reset so nothing leaves the stage before it runs.
    assign oImemReq  = iRst_n && (state == RUN) && (fifo_count < CW'(FIFO_DEPTH)) && !iPCjump;
    assign oImemAddr = fetch_pc;

    assign oInstrValid = (fifo_count != '0);
    assign oInstr      = fifo_head.instr;
    assign oPC         = fifo_head.pc;
    assign oOpcode     = fifo_head.instr[6:0];

    assign fifo_pop   = oInstrValid && iInstrReady;
    assign fifo_flush = iPCjump;
    assign fifo_wdata = '{instr: iImemRdata, pc: req_pc};

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state    <= RUN;
            fetch_pc <= RESET_PC;
            req_pc   <= '0;
        end else begin
            state    <= state_d;
            fetch_pc <= fetch_pc_d;
            req_pc   <= req_pc_d;
        end
    end

    // Next state; a redirect overrides everything and kills any in-flight data.
    always_comb begin
        state_d    = state;
        fetch_pc_d = fetch_pc;
        req_pc_d   = req_pc;
        fifo_push  = 1'b0;
        if (iPCjump) begin
            fetch_pc_d = jump_target;
            case (state)
                RUN:     state_d = RUN;
                WAIT:    state_d = iImemRvalid ? RUN : DROP;
                DROP:    state_d = iImemRvalid ? RUN : DROP;
                default: state_d = RUN;
            endcase
        end else begin
            case (state)
                RUN: begin
                    if (oImemReq && iImemGnt) begin
                        req_pc_d   = fetch_pc;
                        fetch_pc_d = fetch_pc + XLEN'(4);
                        state_d    = WAIT;
                    end
                end
                WAIT: begin
                    if (iImemRvalid) begin
                        fifo_push = 1'b1;
                        state_d   = RUN;
                    end
                end
                DROP: begin
                    if (iImemRvalid) state_d = RUN;
                end
                default: state_d = RUN;
            endcase
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (iClk),
        .rst_n (iRst_n),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .flush (fifo_flush),
        .wdata (fifo_wdata),
        .count (fifo_count),
        .head  (fifo_head)
    );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: sequencing, back-pressure, redirects, reset recovery.
module tb_instr_fetch_unit;
    import fetch_pkg::*;

    localparam int unsigned FIFO_DEPTH = 2;

    logic        iClk;
    logic        iRst_n;
    logic        oImemReq;
    logic [31:0] oImemAddr;
    logic        iImemGnt;
    logic        iImemRvalid;
    logic [31:0] iImemRdata;
    logic        oInstrValid;
    logic        iInstrReady;
    logic [31:0] oInstr;
    logic [31:0] oPC;
    logic [6:0]  oOpcode;
    logic        iPCjump;
    logic [31:0] iBranchPC;
    logic [31:0] iBranchImm;

    int n_checks = 0;
    int n_pass   = 0;
    logic mem_auto;

    instr_fetch_unit #(
        .XLEN       (32),
        .RESET_PC   (32'h0000_0000),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .iClk        (iClk),
        .iRst_n      (iRst_n),
        .oImemReq    (oImemReq),
        .oImemAddr   (oImemAddr),
        .iImemGnt    (iImemGnt),
        .iImemRvalid (iImemRvalid),
        .iImemRdata  (iImemRdata),
        .oInstrValid (oInstrValid),
        .iInstrReady (iInstrReady),
        .oInstr      (oInstr),
        .oPC         (oPC),
        .oOpcode     (oOpcode),
        .iPCjump     (iPCjump),
        .iBranchPC   (iBranchPC),
        .iBranchImm  (iBranchImm)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        else n_pass++;
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a << 8) | NOP_INSTR;
    endfunction

    // One clock; when mem_auto is set the memory answers one cycle after a grant.
    task automatic tick();
        logic        fire;
        logic [31:0] addr;
        @(negedge iClk);
        fire = oImemReq && iImemGnt;
        addr = oImemAddr;
        @(posedge iClk);
        #1;
        if (mem_auto) begin
            iImemRvalid = fire;
            iImemRdata  = fire ? mem_word(addr) : 32'h0;
        end
        #1;
    endtask

    task automatic apply_reset();
        @(posedge iClk);
        #2;
        iRst_n      = 1'b0;
        iImemRvalid = 1'b0;
        iPCjump     = 1'b0;
        repeat (2) @(posedge iClk);
        #2;
        iRst_n = 1'b1;
        #1;
    endtask

    // The FIFO must never see a push while it is full.
    always @(negedge iClk) begin
        if (iRst_n && dut.fifo_push)
            check("push_not_full", 32'(dut.fifo_count < 2'(FIFO_DEPTH)), 32'd1);
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        iRst_n = 1'b0; iImemGnt = 1'b1; iImemRvalid = 1'b0; iImemRdata = '0;
        iInstrReady = 1'b1; iPCjump = 1'b0; iBranchPC = '0; iBranchImm = '0;
        mem_auto = 1'b1;
        repeat (2) @(posedge iClk);
        #2;
        check("rst_req",   32'(oImemReq),    32'd0);
        check("rst_valid", 32'(oInstrValid), 32'd0);
        check("rst_instr", oInstr,           32'h0);
        check("rst_pc",    oPC,              32'h0);
        check("rst_addr",  oImemAddr,        32'h0);
        iRst_n = 1'b1;
        #1;

        // 1: sequential fetch at zero wait, decode always ready
        for (int i = 0; i < 3; i++) begin
            check("seq_req",    32'(oImemReq), 32'd1);
            check("seq_addr",   oImemAddr,     32'(4 * i));
            tick();
            check("seq_wait",   32'(oImemReq),    32'd0);
            check("seq_novld",  32'(oInstrValid), 32'd0);
            tick();
            check("seq_valid",  32'(oInstrValid), 32'd1);
            check("seq_pc",     oPC,              32'(4 * i));
            check("seq_instr",  oInstr,           mem_word(32'(4 * i)));
            check("seq_opcode", 32'(oOpcode),     32'h13);
        end

        // 2: back-pressure fills both entries and stalls requests
        iInstrReady = 1'b0;
        apply_reset();
        for (int t = 1; t <= 10; t++) begin
            tick();
            if (t >= 3) check("full_noreq", 32'(oImemReq), 32'd0);
            if (t >= 2) begin
                check("full_valid", 32'(oInstrValid), 32'd1);
                check("full_head",  oPC,              32'h0);
            end
        end
        iInstrReady = 1'b1;
        #1;
        check("full_head_hold", oPC, 32'h0);
        tick();
        check("full_second", oPC,            32'h4);
        check("full_addr",   oImemAddr,      32'h8);
        check("full_req",    32'(oImemReq),  32'd1);

        // 3: redirect while WAIT with late response
        mem_auto = 1'b0;
        apply_reset();
        check("drop_req0", 32'(oImemReq), 32'd1);
        tick();
        check("drop_wait", 32'(oImemReq), 32'd0);
        iPCjump = 1'b1; iBranchPC = 32'h10; iBranchImm = 32'hFFFF_FFF8;
        #1;
        tick();
        iPCjump = 1'b0;
        #1;
        check("drop_noreq", 32'(oImemReq),    32'd0);
        check("drop_empty", 32'(oInstrValid), 32'd0);
        iImemRvalid = 1'b1; iImemRdata = 32'hDEAD_BEEF;
        #1;
        tick();
        iImemRvalid = 1'b0;
        #1;
        check("drop_discard", 32'(oInstrValid), 32'd0);
        check("drop_req",     32'(oImemReq),    32'd1);
        check("drop_addr",    oImemAddr,        32'h8);
        mem_auto = 1'b1;
        tick();
        check("drop_wait2", 32'(oInstrValid), 32'd0);
        tick();
        check("drop_valid", 32'(oInstrValid), 32'd1);
        check("drop_pc",    oPC,              32'h8);
        check("drop_instr", oInstr,           32'h0000_0813);

        // 4: redirect coinciding with rvalid
        tick();
        iPCjump = 1'b1; iBranchPC = 32'h20; iBranchImm = 32'h40;
        #1;
        check("same_req", 32'(oImemReq), 32'd0);
        tick();
        iPCjump = 1'b0;
        #1;
        check("same_novld", 32'(oInstrValid), 32'd0);
        check("same_req1",  32'(oImemReq),    32'd1);
        check("same_addr",  oImemAddr,        32'h60);
        tick();
        check("same_nostale", 32'(oInstrValid), 32'd0);
        tick();
        check("same_valid", 32'(oInstrValid), 32'd1);
        check("same_pc",    oPC,              32'h60);
        check("same_instr", oInstr,           32'h0000_6013);

        // 5: misaligned target is word-aligned
        iPCjump = 1'b1; iBranchPC = 32'h100; iBranchImm = 32'h3;
        #1;
        check("align_blocked", 32'(oImemReq), 32'd0);
        tick();
        iPCjump = 1'b0;
        #1;
        check("align_addr",  oImemAddr,        32'h100);
        check("align_req",   32'(oImemReq),    32'd1);
        check("align_flush", 32'(oInstrValid), 32'd0);

        // 6: reset mid-WAIT, then a stray response
        mem_auto = 1'b0;
        tick();
        check("mrst_wait", 32'(oImemReq), 32'd0);
        iRst_n = 1'b0;
        #1;
        check("mrst_req",   32'(oImemReq),    32'd0);
        check("mrst_valid", 32'(oInstrValid), 32'd0);
        check("mrst_addr",  oImemAddr,        32'h0);
        repeat (2) @(posedge iClk);
        #2;
        iRst_n = 1'b1; iImemGnt = 1'b0;
        #1;
        check("mrst_req1", 32'(oImemReq), 32'd1);
        iImemRvalid = 1'b1; iImemRdata = 32'hDEAD_BEEF;
        tick();
        iImemRvalid = 1'b0;
        #1;
        check("stray_nopush", 32'(oInstrValid), 32'd0);
        check("stray_addr",   oImemAddr,        32'h0);
        iImemGnt = 1'b1; mem_auto = 1'b1;
        tick();
        tick();
        check("mrst_valid1", 32'(oInstrValid), 32'd1);
        check("mrst_pc",     oPC,              32'h0);
        check("mrst_instr",  oInstr,           32'h0000_0013);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
